// File: rtl/wb_arbiter_pkg.sv
// Shared register-file constants and helpers for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    function automatic logic [REG_COUNT-1:0] rd_onehot(
        input logic [REG_ADDR_W-1:0] rd
    );
        logic [REG_COUNT-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Circular buffer of long-latency results with per-entry live bits
// and a broadcast squash compare against the ALU destination.
module wb_ll_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  logic [REG_ADDR_W-1:0]                 push_rd,
    input  logic [DATA_W-1:0]                     push_data,
    input  logic                                  push_live,
    input  logic                                  pop,
    input  logic                                  squash_en,
    input  logic [REG_ADDR_W-1:0]                 squash_rd,
    output logic [REG_ADDR_W-1:0]                 head_rd,
    output logic [DATA_W-1:0]                     head_data,
    output logic                                  head_live,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      ent_rd,
    output logic [DEPTH-1:0]                      ent_live,
    output logic [$clog2(DEPTH):0]                count,
    output logic                                  full,
    output logic                                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q;
    logic [DEPTH-1:0][DATA_W-1:0]     data_q;
    logic [DEPTH-1:0]                 live_q;
    logic [PTR_W-1:0]                 wr_ptr;
    logic [PTR_W-1:0]                 rd_ptr;
    logic [CNT_W-1:0]                 count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr]   <= push_rd;
            data_q[wr_ptr] <= push_data;
        end
    end

    // Live bits of unoccupied slots are held at 0 so the pending
    // reduction can OR every slot without an occupancy mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            live_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && rd_q[i] == squash_rd)
                    live_q[i] <= 1'b0;
            end
            if (pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                live_q[wr_ptr] <= push_live;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    assign head_rd   = rd_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign head_live = live_q[rd_ptr];
    assign ent_rd    = rd_q;
    assign ent_live  = live_q;
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the regfile port outright,
// long-latency results drain from a small FIFO when the port is free.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [4:0]              alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    ll_valid,
    output logic                    ll_ready,
    input  logic [4:0]              ll_rd,
    input  logic [DATA_W-1:0]       ll_data,
    output logic                    rf_wrd,
    output logic [4:0]              rf_addr_d,
    output logic [DATA_W-1:0]       rf_d,
    output logic [31:0]             pending,
    output logic [$clog2(DEPTH):0]  ll_count
);

    logic                                aw;
    logic                                push;
    logic                                push_live;
    logic                                pop;
    logic [REG_ADDR_W-1:0]               head_rd;
    logic [DATA_W-1:0]                   head_data;
    logic                                head_live;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd;
    logic [DEPTH-1:0]                    ent_live;
    logic                                full;
    logic                                empty;

    assign aw        = alu_valid && (alu_rd != '0);
    assign ll_ready  = !full;
    assign push      = ll_valid && ll_ready;
    // An ALU write in the accept cycle is younger, so the entry is born dead.
    assign push_live = (ll_rd != '0) && !(aw && alu_rd == ll_rd);
    assign pop       = !empty && (!head_live || !aw);

    wb_ll_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_rd   (ll_rd),
        .push_data (ll_data),
        .push_live (push_live),
        .pop       (pop),
        .squash_en (aw),
        .squash_rd (alu_rd),
        .head_rd   (head_rd),
        .head_data (head_data),
        .head_live (head_live),
        .ent_rd    (ent_rd),
        .ent_live  (ent_live),
        .count     (ll_count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        rf_wrd    = 1'b0;
        rf_addr_d = '0;
        rf_d      = '0;
        if (aw) begin
            rf_wrd    = 1'b1;
            rf_addr_d = alu_rd;
            rf_d      = alu_data;
        end else if (pop && head_live) begin
            rf_wrd    = 1'b1;
            rf_addr_d = head_rd;
            rf_d      = head_data;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live[i])
                pending = pending | rd_onehot(ent_rd[i]);
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue model.
module tb_wb_arbiter;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ll_valid;
    logic              ll_ready;
    logic [4:0]        ll_rd;
    logic [DATA_W-1:0] ll_data;
    logic              rf_wrd;
    logic [4:0]        rf_addr_d;
    logic [DATA_W-1:0] rf_d;
    logic [31:0]       pending;
    logic [CW-1:0]     ll_count;

    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ll_valid  (ll_valid),
        .ll_ready  (ll_ready),
        .ll_rd     (ll_rd),
        .ll_data   (ll_data),
        .rf_wrd    (rf_wrd),
        .rf_addr_d (rf_addr_d),
        .rf_d      (rf_d),
        .pending   (pending),
        .ll_count  (ll_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        bit                live;
    } ent_t;

    ent_t              q[$];
    logic [DATA_W-1:0] model_rf[32];
    logic [DATA_W-1:0] dut_rf[32];
    int                checks = 0;
    int                errors = 0;

    logic              s_wrd;
    logic [4:0]        s_addr;
    logic [DATA_W-1:0] s_d;
    logic [31:0]       s_pend;
    logic [CW-1:0]     s_cnt;
    logic              s_ready;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Outputs from the current queue and inputs, then advance the queue.
    task automatic model_cycle();
        bit                aw, pop, wr, acc;
        logic [4:0]        e_addr;
        logic [DATA_W-1:0] e_d;
        logic [31:0]       e_pend;
        ent_t              n;
        aw     = alu_valid && alu_rd != 0;
        e_pend = '0;
        foreach (q[i]) if (q[i].live) e_pend[q[i].rd] = 1'b1;
        pop    = q.size() > 0 && (!q[0].live || !aw);
        wr     = aw || (pop && q[0].live);
        e_addr = aw ? alu_rd : (wr ? q[0].rd : 5'd0);
        e_d    = aw ? alu_data : (wr ? q[0].data : '0);
        s_wrd = rf_wrd; s_addr = rf_addr_d; s_d = rf_d;
        s_pend = pending; s_cnt = ll_count; s_ready = ll_ready;
        chk("rf_wrd", 64'(rf_wrd), 64'(wr));
        chk("rf_addr_d", 64'(rf_addr_d), 64'(e_addr));
        chk("rf_d", 64'(rf_d), 64'(e_d));
        chk("pending", 64'(pending), 64'(e_pend));
        chk("ll_count", 64'(ll_count), 64'(q.size()));
        chk("ll_ready", 64'(ll_ready), 64'(q.size() < DEPTH));
        if (wr) model_rf[e_addr] = e_d;
        if (rf_wrd) dut_rf[rf_addr_d] = rf_d;
        acc = ll_valid && q.size() < DEPTH;
        if (aw) foreach (q[i]) if (q[i].rd == alu_rd) q[i].live = 0;
        if (pop) void'(q.pop_front());
        if (acc) begin
            n.rd   = ll_rd;
            n.data = ll_data;
            n.live = ll_rd != 0 && !(aw && alu_rd == ll_rd);
            q.push_back(n);
        end
    endtask

    task automatic step(input bit av, input logic [4:0] ard,
                        input logic [31:0] ad, input bit lv,
                        input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ll_valid = lv; ll_rd = lrd; ll_data = ld;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ll_valid = 0; ll_rd = 0; ll_data = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
    endtask

    initial begin
        logic [4:0] pick[6];
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end
        reset = 1'b1;
        @(posedge clk);
        do_reset();

        idle();
        chk("reset_count", 64'(s_cnt), 64'd0);
        chk("reset_ready", 64'(s_ready), 64'd1);
        chk("reset_pend", 64'(s_pend), 64'd0);
        chk("reset_wrd", 64'(s_wrd), 64'd0);

        step(1, 5, 32'hDEADBEEF, 0, 0, 0);
        chk("t1_wrd", 64'(s_wrd), 64'd1);
        chk("t1_addr", 64'(s_addr), 64'd5);
        chk("t1_d", 64'(s_d), 64'hDEADBEEF);
        chk("t1_pend", 64'(s_pend), 64'd0);

        step(0, 0, 0, 1, 7, 32'h1234);
        chk("t2_nowrite", 64'(s_wrd), 64'd0);
        idle();
        chk("t2_addr", 64'(s_addr), 64'd7);
        chk("t2_d", 64'(s_d), 64'h1234);
        chk("t2_pend", 64'(s_pend), 64'h80);
        idle();
        chk("t2_pend_clr", 64'(s_pend), 64'd0);

        step(1, 4, 32'h44, 1, 3, 32'h33);
        step(1, 4, 32'h45, 0, 0, 0);
        chk("t3_alu_wins", 64'(s_addr), 64'd4);
        chk("t3_pend", 64'(s_pend), 64'h8);
        step(1, 4, 32'h46, 0, 0, 0);
        idle();
        chk("t3_drain_addr", 64'(s_addr), 64'd3);
        chk("t3_drain_d", 64'(s_d), 64'h33);

        step(1, 4, 1, 1, 10, 32'hA0);
        step(1, 4, 2, 1, 11, 32'hB0);
        step(1, 4, 3, 1, 12, 32'hC0);
        chk("t4_ready", 64'(s_ready), 64'd0);
        chk("t4_count", 64'(s_cnt), 64'd2);
        idle();
        chk("t4_first", 64'(s_addr), 64'd10);
        idle();
        chk("t4_second", 64'(s_addr), 64'd11);
        idle();
        chk("t4_third_dropped", 64'(s_wrd), 64'd0);

        step(0, 0, 0, 1, 9, 32'h99);
        step(1, 9, 32'hAAAA, 0, 0, 0);
        chk("t5_pend_live", 64'(s_pend), 64'h200);
        idle();
        chk("t5_pend_sq", 64'(s_pend), 64'd0);
        chk("t5_silent", 64'(s_wrd), 64'd0);
        chk("t5_cnt", 64'(s_cnt), 64'd1);
        idle();
        chk("t5_x9", 64'(dut_rf[9]), 64'hAAAA);
        step(1, 9, 32'hBBBB, 1, 9, 32'h77);
        idle();
        chk("t5b_cnt", 64'(s_cnt), 64'd1);
        chk("t5b_pend", 64'(s_pend), 64'd0);
        chk("t5b_wrd", 64'(s_wrd), 64'd0);
        idle();
        chk("t5b_x9", 64'(dut_rf[9]), 64'hBBBB);

        step(0, 0, 0, 1, 0, 32'h55);
        idle();
        chk("t6_rd0_pend", 64'(s_pend), 64'd0);
        chk("t6_rd0_wrd", 64'(s_wrd), 64'd0);
        idle();
        step(1, 4, 5, 1, 12, 32'hC1);
        step(1, 4, 6, 1, 13, 32'hD1);
        do_reset();
        idle();
        chk("t6_rst_cnt", 64'(s_cnt), 64'd0);
        chk("t6_rst_ready", 64'(s_ready), 64'd1);
        chk("t6_rst_wrd", 64'(s_wrd), 64'd0);
        chk("t6_rst_pend", 64'(s_pend), 64'd0);

        pick = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 5'd31};
        for (int n = 0; n < 2000; n++) begin
            logic [4:0] ar, lr;
            ar = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                             : pick[$urandom_range(0, 5)];
            lr = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                             : pick[$urandom_range(0, 5)];
            if ($urandom_range(0, 99) == 0) do_reset();
            step(1'($urandom_range(0, 99) < 45), ar, $urandom,
                 1'($urandom_range(0, 99) < 60), lr, $urandom);
        end
        for (int i = 0; i < 4; i++) idle();
        for (int i = 0; i < 32; i++)
            chk($sformatf("rf_x%0d", i), 64'(dut_rf[i]), 64'(model_rf[i]));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
